// File: rtl/tlc_disp_if.sv
// Bundle between the traffic-light controller (master) and the countdown display (slave):
// phase/count in, multiplexed 7-segment drive plus status flags out.
interface tlc_disp_if;
  logic [1:0] phase;
  logic [3:0] phase_cnt;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       phase_chg;
  logic       err;

  // No handshake: phase/phase_cnt are level signals sampled every clock; outputs are registered levels/pulses.
  modport master (
    output phase, phase_cnt,
    input  seg_n, an_n, phase_chg, err
  );

  modport slave (
    input  phase, phase_cnt,
    output seg_n, an_n, phase_chg, err
  );
endinterface

// File: rtl/tlc_countdown_display.sv
// Seconds-remaining countdown on a 2-digit multiplexed common-anode 7-segment display.
// Optional blink of the last seconds is enabled with `define TLC_DISP_BLINK_EN.
module tlc_countdown_display #(
  parameter int RED_END     = 5,
  parameter int GRN_END     = 10,
  parameter int YEL_END     = 15,
  parameter int REFRESH_DIV = 50000
`ifdef TLC_DISP_BLINK_EN
  ,
  parameter int BLINK_TH    = 2,
  parameter int BLINK_DIV   = 8
`endif
) (
  input  logic      clk,
  input  logic      rst,
  tlc_disp_if.slave disp
);
  localparam int            RW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_MAX   = RW'(REFRESH_DIV - 1);
  localparam logic [1:0]    PH_RED    = 2'b00;
  localparam logic [1:0]    PH_GRN    = 2'b11;
  localparam logic [1:0]    PH_YEL    = 2'b01;
  localparam logic [1:0]    PH_ERR    = 2'b10;
  localparam logic [6:0]    SEG_BLANK = 7'h7F;
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  logic [1:0]    phase_q, prev_phase_q;
  logic [3:0]    cnt_q;
  logic [3:0]    end_val, rem_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic          sel_q, sel_d;  // 0 = ones digit, 1 = tens digit
  logic          wrap, chg_d, err_d;
  logic          phase_chg_q, err_q;
  logic [6:0]    seg_n_q, seg_n_d;
  logic [1:0]    an_n_q;

`ifdef TLC_DISP_BLINK_EN
  localparam int            BW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
  logic [3:0]    rem_q;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_odd_q, blink_odd_d;
`endif

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b1000000;
      4'd1:    seg_encode = 7'b1111001;
      4'd2:    seg_encode = 7'b0100100;
      4'd3:    seg_encode = 7'b0110000;
      4'd4:    seg_encode = 7'b0011001;
      4'd5:    seg_encode = 7'b0010010;
      4'd6:    seg_encode = 7'b0000010;
      4'd7:    seg_encode = 7'b1111000;
      4'd8:    seg_encode = 7'b0000000;
      4'd9:    seg_encode = 7'b0010000;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    end_val = 4'd0;
    case (phase_q)
      PH_RED:  end_val = 4'(RED_END);
      PH_GRN:  end_val = 4'(GRN_END);
      PH_YEL:  end_val = 4'(YEL_END);
      default: end_val = 4'd0;
    endcase
    // Count past the phase end saturates at zero rather than wrapping.
    rem_d = (cnt_q <= end_val) ? (end_val - cnt_q) : 4'd0;
    if (rem_d >= 4'd10) begin
      tens_d = 4'd1;
      ones_d = rem_d - 4'd10;
    end else begin
      tens_d = 4'd0;
      ones_d = rem_d;
    end

    wrap      = (refresh_q == REF_MAX);
    refresh_d = wrap ? '0 : refresh_q + RW'(1);
    sel_d     = wrap ? ~sel_q : sel_q;
    chg_d     = (phase_q != prev_phase_q);
    err_d     = (phase_q == PH_ERR);

    if (err_q)                        seg_n_d = SEG_DASH;
    else if (sel_q && tens_q == 4'd0) seg_n_d = SEG_BLANK;
    else                              seg_n_d = seg_encode(sel_q ? tens_q : ones_q);

`ifdef TLC_DISP_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    blink_odd_d = blink_odd_q;
    if (chg_d) begin
      blink_cnt_d = '0;
      blink_odd_d = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        blink_odd_d = ~blink_odd_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    if (blink_odd_q && !err_q && rem_q <= 4'(BLINK_TH)) seg_n_d = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q      <= PH_RED;
      prev_phase_q <= PH_RED;
      cnt_q        <= 4'd0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      refresh_q    <= '0;
      sel_q        <= 1'b0;
      phase_chg_q  <= 1'b0;
      err_q        <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= 2'b11;
`ifdef TLC_DISP_BLINK_EN
      rem_q        <= 4'd0;
      blink_cnt_q  <= '0;
      blink_odd_q  <= 1'b0;
`endif
    end else begin
      phase_q      <= disp.phase;
      prev_phase_q <= phase_q;
      cnt_q        <= disp.phase_cnt;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      refresh_q    <= refresh_d;
      sel_q        <= sel_d;
      phase_chg_q  <= chg_d;
      err_q        <= err_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= sel_q ? 2'b01 : 2'b10;
`ifdef TLC_DISP_BLINK_EN
      rem_q        <= rem_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_odd_q  <= blink_odd_d;
`endif
    end
  end

  assign disp.seg_n     = seg_n_q;
  assign disp.an_n      = an_n_q;
  assign disp.phase_chg = phase_chg_q;
  assign disp.err       = err_q;
endmodule

// File: tb/tb_tlc_countdown_display.sv
// Directed bench for tlc_countdown_display with REFRESH_DIV=4 (and BLINK_DIV=2 when blinking is built in).
module tb_tlc_countdown_display;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'b0111111;
`ifdef TLC_DISP_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] seg_tab [10];

  always #5 clk = ~clk;

  tlc_disp_if bus ();

`ifdef TLC_DISP_BLINK_EN
  tlc_countdown_display #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (.clk(clk), .rst(rst), .disp(bus));
`else
  tlc_countdown_display #(.REFRESH_DIV(4)) dut (.clk(clk), .rst(rst), .disp(bus));
`endif

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.phase = 2'b00;
    bus.phase_cnt = 4'd2;
    step(3);
    checks++; if (bus.seg_n !== BLANK) begin errors++; $display("FAIL reset_seg got %h want %h", bus.seg_n, BLANK); end
    checks++; if (bus.an_n !== 2'b11) begin errors++; $display("FAIL reset_an got %b want 11", bus.an_n); end
    checks++; if (bus.phase_chg !== 1'b0) begin errors++; $display("FAIL reset_chg got %b want 0", bus.phase_chg); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    rst = 1'b1;
    step(1);
    checks++; if (bus.an_n !== 2'b10) begin errors++; $display("FAIL release_an got %b want 10", bus.an_n); end
  endtask

  // Continues from the first edge after reset release: RED, count 2 -> remaining 3.
  task automatic test_scan;
    logic [1:0] exp_an;
    for (int e = 2; e <= 12; e++) begin
      step(1);
      exp_an = (((e - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if (bus.an_n !== exp_an) begin errors++; $display("FAIL scan_an edge %0d got %b want %b", e, bus.an_n, exp_an); end
      checks++; if (bus.phase_chg !== 1'b0) begin errors++; $display("FAIL scan_chg edge %0d got %b want 0", e, bus.phase_chg); end
      if (e >= 3) begin
        checks++;
        if (bus.seg_n !== ((exp_an == 2'b10) ? seg_tab[3] : BLANK)) begin
          errors++; $display("FAIL scan_seg edge %0d got %b an %b", e, bus.seg_n, bus.an_n);
        end
      end
    end
  endtask

  task automatic test_phase_change;
    bus.phase = 2'b11;
    bus.phase_cnt = 4'd6;
    step(1);
    checks++; if (bus.phase_chg !== 1'b0) begin errors++; $display("FAIL chg_early got %b want 0", bus.phase_chg); end
    step(1);
    checks++; if (bus.phase_chg !== 1'b1) begin errors++; $display("FAIL chg_pulse got %b want 1", bus.phase_chg); end
    step(1);
    checks++; if (bus.phase_chg !== 1'b0) begin errors++; $display("FAIL chg_end got %b want 0", bus.phase_chg); end
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (bus.an_n == 2'b10) begin
        if (bus.seg_n !== seg_tab[4]) begin errors++; $display("FAIL chg_ones got %b want %b", bus.seg_n, seg_tab[4]); end
      end else if (bus.an_n == 2'b01) begin
        if (bus.seg_n !== BLANK) begin errors++; $display("FAIL chg_tens got %b want %b", bus.seg_n, BLANK); end
      end else begin
        errors++; $display("FAIL chg_an got %b want 10 or 01", bus.an_n);
      end
    end
  endtask

  // Table of {phase, count, hand-computed remaining seconds}, including saturation and two-digit cases.
  task automatic test_remaining;
    logic [1:0] vp [7];
    logic [3:0] vc [7];
    int         vr [7];
    logic [6:0] exp_ones, exp_tens;
    vp = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01};
    vc = '{4'd12, 4'd10, 4'd0,  4'd0,  4'd5,  4'd6,  4'd11};
    vr = '{0,     0,     10,    15,    0,     0,     4};
    for (int v = 0; v < 7; v++) begin
      bus.phase = vp[v];
      bus.phase_cnt = vc[v];
      exp_ones = seg_tab[vr[v] % 10];
      exp_tens = (vr[v] >= 10) ? seg_tab[1] : BLANK;
      step(3);
      for (int i = 0; i < 8; i++) begin
        step(1);
        checks++;
        if (bus.an_n == 2'b10) begin
          if (bus.seg_n !== exp_ones && !(BLINK_BUILD && vr[v] <= 2 && bus.seg_n == BLANK)) begin
            errors++; $display("FAIL rem_ones vec %0d got %b want %b", v, bus.seg_n, exp_ones);
          end
        end else if (bus.an_n == 2'b01) begin
          if (bus.seg_n !== exp_tens) begin errors++; $display("FAIL rem_tens vec %0d got %b want %b", v, bus.seg_n, exp_tens); end
        end else begin
          errors++; $display("FAIL rem_an vec %0d got %b want 10 or 01", v, bus.an_n);
        end
      end
    end
  endtask

  task automatic test_err;
    bus.phase = 2'b10;
    step(1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_early got %b want 0", bus.err); end
    step(1);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", bus.err); end
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (bus.seg_n !== DASH || (bus.an_n != 2'b10 && bus.an_n != 2'b01)) begin
        errors++; $display("FAIL err_dash got seg %b an %b want seg %b", bus.seg_n, bus.an_n, DASH);
      end
    end
    bus.phase = 2'b01;
    bus.phase_cnt = 4'd10;
    step(1);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL err_hold got %b want 1", bus.err); end
    step(1);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", bus.err); end
    step(2);
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (bus.seg_n !== ((bus.an_n == 2'b10) ? seg_tab[5] : BLANK) || (bus.an_n != 2'b10 && bus.an_n != 2'b01)) begin
        errors++; $display("FAIL err_after got seg %b an %b want ones %b", bus.seg_n, bus.an_n, seg_tab[5]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bus.phase = 2'b10;
    step(5);
    rst = 1'b0;
    bus.phase = 2'b11;
    bus.phase_cnt = 4'd3;
    step(1);
    checks++; if (bus.seg_n !== BLANK) begin errors++; $display("FAIL mid_seg got %b want %b", bus.seg_n, BLANK); end
    checks++; if (bus.an_n !== 2'b11) begin errors++; $display("FAIL mid_an got %b want 11", bus.an_n); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mid_err got %b want 0", bus.err); end
    rst = 1'b1;
    step(1);
    checks++; if (bus.an_n !== 2'b10) begin errors++; $display("FAIL mid_release_an got %b want 10", bus.an_n); end
    step(1);
    checks++; if (bus.phase_chg !== 1'b1) begin errors++; $display("FAIL mid_chg got %b want 1", bus.phase_chg); end
    step(1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (bus.seg_n !== ((bus.an_n == 2'b10) ? seg_tab[7] : BLANK) || (bus.an_n != 2'b10 && bus.an_n != 2'b01)) begin
        errors++; $display("FAIL mid_digits got seg %b an %b want ones %b", bus.seg_n, bus.an_n, seg_tab[7]);
      end
    end
  endtask

`ifdef TLC_DISP_BLINK_EN
  task automatic test_blink;
    int ones_cycles, blank_cycles;
    ones_cycles = 0;
    blank_cycles = 0;
    bus.phase = 2'b01;
    bus.phase_cnt = 4'd14;
    step(6);
    for (int i = 0; i < 32; i++) begin
      step(1);
      if (bus.an_n == 2'b10) begin
        ones_cycles++;
        if (bus.seg_n == BLANK) blank_cycles++;
        else begin
          checks++;
          if (bus.seg_n !== seg_tab[1]) begin errors++; $display("FAIL blink_lit got %b want %b", bus.seg_n, seg_tab[1]); end
        end
      end
    end
    checks++; if (ones_cycles != 16) begin errors++; $display("FAIL blink_ones got %0d want 16", ones_cycles); end
    checks++; if (blank_cycles != 8) begin errors++; $display("FAIL blink_blank got %0d want 8", blank_cycles); end
  endtask
`endif

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    bus.phase = 2'b00;
    bus.phase_cnt = 4'd0;
    test_reset();
    test_scan();
    test_phase_change();
    test_remaining();
    test_err();
    test_reset_mid();
`ifdef TLC_DISP_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
